// File: rtl/mvd_sched_pkg.sv
// rtl/mvd_sched_pkg.sv - shared job type, FSM encoding and default sizes for the mvd cost scheduler
package mvd_sched_pkg;

    localparam int MVD_NUM_REQ_DEF = 4;
    localparam int MVD_TIMEOUT_DEF = 64;

    typedef struct packed {
        logic [31:0]      x;
        logic [31:0]      y;
        logic [31:0]      mv_shift;
        logic [3:0][15:0] mv_cand;
        logic [63:0]      lambda_sqrt_integer;
        logic [63:0]      lambda_sqrt_decimal;
    } mvd_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mvd_state_e;

endpackage

// File: rtl/mvd_cost_sched_if.sv
// rtl/mvd_cost_sched_if.sv - requester, core and response signals of the mvd cost scheduler
interface mvd_cost_sched_if
    import mvd_sched_pkg::*;
#(
    parameter int NUM_REQ = MVD_NUM_REQ_DEF
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_vld;
    logic [NUM_REQ-1:0]           req_rdy;
    mvd_req_t [NUM_REQ-1:0]       req_data;

    logic                         core_start;
    mvd_req_t                     core_req;
    logic [63:0]                  core_bitcost;
    logic                         core_bitcost_vld;
    logic [63:0]                  core_mvd_cost;
    logic                         core_mvd_cost_vld;

    logic                         rsp_vld;
    logic                         rsp_rdy;
    logic [IDX_W-1:0]             rsp_id;
    logic [63:0]                  rsp_bitcost;
    logic [63:0]                  rsp_mvd_cost;
    logic                         rsp_err;
    logic                         busy;

    modport slave (
        input  req_vld, req_data,
        input  core_bitcost, core_bitcost_vld, core_mvd_cost, core_mvd_cost_vld,
        input  rsp_rdy,
        output req_rdy, core_start, core_req,
        output rsp_vld, rsp_id, rsp_bitcost, rsp_mvd_cost, rsp_err, busy
    );

    modport master (
        output req_vld, req_data,
        output core_bitcost, core_bitcost_vld, core_mvd_cost, core_mvd_cost_vld,
        output rsp_rdy,
        input  req_rdy, core_start, core_req,
        input  rsp_vld, rsp_id, rsp_bitcost, rsp_mvd_cost, rsp_err, busy
    );

endinterface

// File: rtl/mvd_rr_arb.sv
// rtl/mvd_rr_arb.sv - round-robin one-hot grant, search starts just after last_gnt
module mvd_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_gnt,
    output logic [NUM_REQ-1:0]         gnt
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] w_sel;
    logic             w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sel = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!w_found && req[w_sel]) begin
                gnt[w_sel] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mvd_cost_sched.sv
// rtl/mvd_cost_sched.sv - shares one calc_mvd_cost core among NUM_REQ requesters; MVD_SCHED_TIMEOUT_EN adds a WAIT watchdog
module mvd_cost_sched
    import mvd_sched_pkg::*;
#(
    parameter int NUM_REQ        = MVD_NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = MVD_TIMEOUT_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    mvd_cost_sched_if.slave   s_if
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_START = ST_START;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_RESP  = ST_RESP;

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_last_gnt;
    logic [IDX_W-1:0]   r_id;
    mvd_req_t           r_core_req;
    logic [63:0]        r_bitcost;
    logic [63:0]        r_mvd_cost;
    logic               r_bc_flag;
    logic               r_mc_flag;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_accept;
    logic               w_cap_win;
    logic               w_bc_cap;
    logic               w_mc_cap;
    logic               w_both_done;
    logic               w_timeout;

    mvd_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .req      (s_if.req_vld),
        .last_gnt (r_last_gnt),
        .gnt      (w_gnt)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = IDX_W'(i);
            end
        end
    end

    // Only the first valid pulse of each result is kept; later pulses are ignored.
    assign w_accept    = (r_state == S_IDLE) && (|(s_if.req_vld & w_gnt));
    assign w_cap_win   = (r_state == S_START) || (r_state == S_WAIT);
    assign w_bc_cap    = w_cap_win && s_if.core_bitcost_vld && !r_bc_flag;
    assign w_mc_cap    = w_cap_win && s_if.core_mvd_cost_vld && !r_mc_flag;
    assign w_both_done = (r_bc_flag || w_bc_cap) && (r_mc_flag || w_mc_cap);

`ifdef MVD_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    // Cleared while in START so the count is zero on the first WAIT cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_START) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !w_both_done &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign s_if.rsp_err = r_err;
`else
    assign w_timeout    = 1'b0;
    assign s_if.rsp_err = 1'b0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state    <= S_IDLE;
            r_last_gnt <= IDX_W'(NUM_REQ - 1);
            r_id       <= '0;
            r_core_req <= '0;
            r_bitcost  <= '0;
            r_mvd_cost <= '0;
            r_bc_flag  <= 1'b0;
            r_mc_flag  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_core_req <= s_if.req_data[w_gnt_idx];
                        r_id       <= w_gnt_idx;
                        r_bitcost  <= '0;
                        r_mvd_cost <= '0;
                        r_bc_flag  <= 1'b0;
                        r_mc_flag  <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_both_done || w_timeout) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (s_if.rsp_rdy) begin
                        r_last_gnt <= r_id;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_bc_cap) begin
                r_bitcost <= s_if.core_bitcost;
                r_bc_flag <= 1'b1;
            end
            if (w_mc_cap) begin
                r_mvd_cost <= s_if.core_mvd_cost;
                r_mc_flag  <= 1'b1;
            end
        end
    end

    assign s_if.req_rdy      = (r_state == S_IDLE) ? w_gnt : '0;
    assign s_if.core_start   = (r_state == S_START);
    assign s_if.core_req     = r_core_req;
    assign s_if.rsp_vld      = (r_state == S_RESP);
    assign s_if.rsp_id       = r_id;
    assign s_if.rsp_bitcost  = r_bitcost;
    assign s_if.rsp_mvd_cost = r_mvd_cost;
    assign s_if.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_mvd_cost_sched.sv
// tb/tb_mvd_cost_sched.sv - scoreboard bench for mvd_cost_sched with a latency-programmable core model
module tb_mvd_cost_sched;
    import mvd_sched_pkg::*;

    localparam int NR  = 4;
    localparam int TMO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mvd_cost_sched_if #(.NUM_REQ(NR)) bus ();

    mvd_cost_sched #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .s_if     (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] bc;
        logic [63:0] mc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   gnt_seq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // written by the main process
    int          bc_lat = 1, mc_lat = 1, exp_k = 2;
    bit          core_en = 1'b1, dup = 1'b0, cont_mode = 1'b0, rsp_rdy_want = 1'b1;
    logic [63:0] bc_val = '0, mc_val = '0;
    logic [31:0] job_x[NR];
    logic [31:0] job_y[NR];
    int          post_cnt[NR];

    // written by the monitor process
    int       taken_cnt[NR];
    int       acc_cnt = 0, rsp_cnt = 0, start_cnt = 0;
    int       k = 0;
    bit       active = 1'b0, prev_start = 1'b0, prev_rsp = 1'b0;
    int       model_last = NR - 1;
    mvd_req_t drv_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Core model, requester/response drivers and scoreboard; the only driver of bus inputs.
    initial begin
        exp_t e;
        int   w;
        bus.req_vld           = '0;
        bus.req_data          = '0;
        bus.core_bitcost      = '0;
        bus.core_bitcost_vld  = 1'b0;
        bus.core_mvd_cost     = '0;
        bus.core_mvd_cost_vld = 1'b0;
        bus.rsp_rdy           = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                model_last = NR - 1;
                active     = 1'b0;
                prev_start = 1'b0;
                prev_rsp   = 1'b0;
                for (int i = 0; i < NR; i++) taken_cnt[i] = post_cnt[i];
                bus.req_vld           = '0;
                bus.core_bitcost_vld  = 1'b0;
                bus.core_mvd_cost_vld = 1'b0;
                bus.rsp_rdy           = 1'b0;
                continue;
            end
            if (bus.core_start) begin
                check("start_pulse", 64'(prev_start), 0);
                start_cnt++;
                k      = 0;
                active = 1'b1;
                if (sb.size() > 0) begin
                    check("core_req_x", bus.core_req.x, sb[0].x);
                    check("core_req_y", bus.core_req.y, sb[0].y);
                end else begin
                    check("start_without_job", sb.size(), 1);
                end
            end else if (active) begin
                k++;
            end
            prev_start = bus.core_start;

            bus.core_bitcost_vld  = active && core_en && (k == bc_lat || (dup && k == bc_lat + 1));
            bus.core_bitcost      = (active && k == bc_lat) ? bc_val : (64'hDEAD_0000_0000_0000 | 64'(k));
            bus.core_mvd_cost_vld = active && core_en && (k == mc_lat || (dup && k == mc_lat + 1));
            bus.core_mvd_cost     = (active && k == mc_lat) ? mc_val : (64'hBEEF_0000_0000_0000 | 64'(k));
            for (int i = 0; i < NR; i++) begin
                drv_t                     = '0;
                drv_t.x                   = job_x[i];
                drv_t.y                   = job_y[i];
                drv_t.mv_shift            = 32'(i);
                drv_t.lambda_sqrt_integer = 64'(i + 7);
                bus.req_data[i]           = drv_t;
                bus.req_vld[i]            = cont_mode || (post_cnt[i] != taken_cnt[i]);
            end
            bus.rsp_rdy = rsp_rdy_want;

            #1;
            if (!rst_n) continue;
            if (|(bus.req_vld & bus.req_rdy)) begin
                w = -1;
                for (int s = 1; s <= NR; s++) begin
                    if (w < 0 && bus.req_vld[(model_last + s) % NR]) w = (model_last + s) % NR;
                end
                check("grant", 64'(bus.req_rdy), 64'(1) << w);
                e.id  = w;
                e.x   = job_x[w];
                e.y   = job_y[w];
                e.bc  = core_en ? bc_val : 64'd0;
                e.mc  = core_en ? mc_val : 64'd0;
                e.err = !core_en;
                sb.push_back(e);
                gnt_seq.push_back(w);
                acc_cnt++;
                if (!cont_mode) taken_cnt[w]++;
            end
            if (bus.rsp_vld && !prev_rsp) check("rsp_latency", k, exp_k);
            prev_rsp = bus.rsp_vld;
            if (bus.rsp_vld && bus.rsp_rdy) begin
                if (sb.size() == 0) begin
                    check("rsp_without_job", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 64'(bus.rsp_id), e.id);
                    check("rsp_bitcost", bus.rsp_bitcost, e.bc);
                    check("rsp_mvd_cost", bus.rsp_mvd_cost, e.mc);
                    check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    model_last = e.id;
                end
                rsp_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic [31:0] x, input logic [31:0] y);
        job_x[i] = x;
        job_y[i] = y;
        post_cnt[i]++;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int c = 0;
        while (rsp_cnt < n && c < budget) begin
            tick(1);
            c++;
        end
        check("wait_rsp", rsp_cnt, n);
    endtask

    task automatic wait_acc(input int n, input int budget);
        int c = 0;
        while (acc_cnt < n && c < budget) begin
            tick(1);
            c++;
        end
        check("wait_acc", acc_cnt, n);
    endtask

    initial begin
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int n0;
        int c;
        for (int i = 0; i < NR; i++) begin
            job_x[i]    = 32'h100 + 32'(i);
            job_y[i]    = 32'h200 + 32'(i);
            post_cnt[i] = 0;
        end
        tick(3);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_rsp_vld", 64'(bus.rsp_vld), 0);
        check("rst_core_start", 64'(bus.core_start), 0);
        check("rst_req_rdy", 64'(bus.req_rdy), 0);
        check("rst_rsp_err", 64'(bus.rsp_err), 0);
        check("rst_core_req", 64'(bus.core_req.x), 0);

        // all requesters valid from reset release
        bc_val    = 64'h11;
        mc_val    = 64'h22;
        cont_mode = 1'b1;
        rst_n     = 1'b1;
        wait_acc(5, 60);
        cont_mode = 1'b0;
        wait_rsp(5, 60);
        check("rr_seq_len", gnt_seq.size(), 5);
        for (int i = 0; i < 5 && i < gnt_seq.size(); i++) check("rr_seq", gnt_seq[i], exp_seq[i]);
        check("start_per_job", start_cnt, acc_cnt);

        // single job on requester 2, results together 3 cycles after start
        bc_lat = 3; mc_lat = 3; exp_k = 4;
        bc_val = 64'h5; mc_val = 64'h1234;
        post(2, 32'h10, 32'h20);
        wait_rsp(6, 40);

        // split valids with a repeated bitcost pulse
        bc_lat = 2; mc_lat = 5; exp_k = 6; dup = 1'b1;
        bc_val = 64'hABCD_0000_0000_0077; mc_val = 64'h0123_4567_89AB_CDEF;
        post(3, 32'h3333, 32'h4444);
        wait_rsp(7, 40);
        dup = 1'b0;

        // response back-pressure with another requester waiting
        bc_lat = 1; mc_lat = 1; exp_k = 2;
        bc_val = 64'h7777; mc_val = 64'h8888;
        rsp_rdy_want = 1'b0;
        post(2, 32'h2222, 32'h2323);
        c = 0;
        while (!bus.rsp_vld && c < 30) begin
            tick(1);
            c++;
        end
        check("stall_rsp_vld_seen", 64'(bus.rsp_vld), 1);
        post(1, 32'h1111, 32'h1212);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("stall_rsp_vld", 64'(bus.rsp_vld), 1);
            check("stall_rsp_id", 64'(bus.rsp_id), 2);
            check("stall_bitcost", bus.rsp_bitcost, 64'h7777);
            check("stall_mvd_cost", bus.rsp_mvd_cost, 64'h8888);
            check("stall_req_rdy", 64'(bus.req_rdy), 0);
            check("stall_core_start", 64'(bus.core_start), 0);
        end
        rsp_rdy_want = 1'b1;
        wait_rsp(9, 40);

        // core never answers
        core_en = 1'b0;
        exp_k   = TMO + 1;
        post(0, 32'h5050, 32'h6060);
`ifdef MVD_SCHED_TIMEOUT_EN
        wait_rsp(10, TMO + 40);
        post(1, 32'h7070, 32'h8080);
        tick(6);
`else
        tick(120);
        check("hang_no_rsp", rsp_cnt, 9);
        check("hang_rsp_vld", 64'(bus.rsp_vld), 0);
`endif
        check("wait_busy", 64'(bus.busy), 1);

        // reset in the middle of WAIT
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 0);
        check("arst_rsp_vld", 64'(bus.rsp_vld), 0);
        check("arst_core_start", 64'(bus.core_start), 0);
        check("arst_req_rdy", 64'(bus.req_rdy), 0);
        check("arst_bitcost", bus.rsp_bitcost, 0);
        check("arst_core_req", 64'(bus.core_req.x), 0);
        tick(2);
        rst_n   = 1'b1;
        core_en = 1'b1;
        exp_k   = 2;
        bc_val  = 64'h99; mc_val = 64'hAA;
        n0 = gnt_seq.size();
        c  = rsp_cnt;
        post(3, 32'h3030, 32'h3131);
        post(0, 32'h0A0A, 32'h0B0B);
        wait_rsp(c + 2, 40);
        check("post_rst_first", (gnt_seq.size() > n0) ? gnt_seq[n0] : -1, 0);
        check("post_rst_second", (gnt_seq.size() > n0 + 1) ? gnt_seq[n0 + 1] : -1, 3);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
